// File: rtl/cla_chunk_sequencer_if.sv
// Operand/result handshake plus the byte-wide link to the 8-bit CLA slice.
// slave  : the sequencer's view (takes requests, drives the CLA operands).
// master : the requester/adder side's view.
interface cla_chunk_sequencer_if #(
  parameter int WIDTH = 16
);
  // request side
  logic             start;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  // result side
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  // CLA link
  logic [7:0]       add_a;
  logic [7:0]       add_b;
  logic             add_c0;
  logic [7:0]       add_s;
  logic             add_c8;

  modport slave (
    input  start, in_a, in_b, in_cin,
    output busy, done, sum, cout,
    output add_a, add_b, add_c0,
    input  add_s, add_c8
  );

  modport master (
    output start, in_a, in_b, in_cin,
    input  busy, done, sum, cout,
    input  add_a, add_b, add_c0,
    output add_s, add_c8
  );
endinterface

// File: rtl/cla_chunk_sequencer.sv
// Byte-serial WIDTH-bit adder built around an external 8-bit CLA slice.
// One operand byte per RUN cycle goes to the CLA; its carry-out is registered
// and fed back as the next byte's carry-in, and the returned byte sums are
// stitched into the registered result.
module cla_chunk_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cla_chunk_sequencer_if.slave bus
);

  localparam int NCH  = WIDTH / 8;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [IDXW-1:0]   idx_reg;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic              carry_reg;
  logic [WIDTH-1:0]  sum_reg;
  logic              cout_reg;

  // operand registers split into bytes so the CLA mux is a plain array select
  logic [7:0] a_byte [NCH];
  logic [7:0] b_byte [NCH];

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_bytes
      assign a_byte[gi] = a_reg[gi*8 +: 8];
      assign b_byte[gi] = b_reg[gi*8 +: 8];
    end
  endgenerate

  wire last_chunk = (idx_reg == LAST_IDX);

  // next-state: accept in IDLE, walk the bytes in RUN, single DONE cycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_chunk) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // CLA drive comes from registers only, and is held at zero outside RUN
  always_comb begin
    bus.add_a  = 8'h00;
    bus.add_b  = 8'h00;
    bus.add_c0 = 1'b0;
    if (state_reg == RUN) begin
      bus.add_a  = a_byte[idx_reg];
      bus.add_b  = b_byte[idx_reg];
      bus.add_c0 = carry_reg;
    end
  end

  // state, operand capture, byte-result stitching and carry ripple
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg     <= bus.in_a;
            b_reg     <= bus.in_b;
            carry_reg <= bus.in_cin;
            sum_reg   <= '0;
            idx_reg   <= '0;
          end
        end
        RUN: begin
          sum_reg[{idx_reg, 3'b000} +: 8] <= bus.add_s;
          carry_reg <= bus.add_c8;
          if (last_chunk) begin
            cout_reg <= bus.add_c8;
          end else begin
            idx_reg <= idx_reg + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_reg == RUN);
  assign bus.done = (state_reg == DONE);
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;

endmodule

// File: tb/tb_cla_chunk_sequencer.sv
// Directed and random checks of the byte-serial adder at WIDTH = 8, 16, 32,
// each sequencer wired to its own 8-bit carry-look-ahead slice model.
module tb_cla_chunk_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cla_chunk_sequencer_if #(.WIDTH(8))  if8 ();
  cla_chunk_sequencer_if #(.WIDTH(16)) if16 ();
  cla_chunk_sequencer_if #(.WIDTH(32)) if32 ();

  cla_chunk_sequencer #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  cla_chunk_sequencer #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  cla_chunk_sequencer #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

  // 8-bit carry-look-ahead slice: generate/propagate carry recurrence
  function automatic logic [8:0] cla8(input logic [7:0] a, input logic [7:0] b, input logic c0);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = c0;
    for (int i = 0; i < 8; i++) c[i+1] = g[i] | (p[i] & c[i]);
    return {c[8], p ^ c[7:0]};
  endfunction

  // combinational CLA slices hanging off each sequencer
  always_comb {if8.add_c8,  if8.add_s}  = cla8(if8.add_a,  if8.add_b,  if8.add_c0);
  always_comb {if16.add_c8, if16.add_s} = cla8(if16.add_a, if16.add_b, if16.add_c0);
  always_comb {if32.add_c8, if32.add_s} = cla8(if32.add_a, if32.add_b, if32.add_c0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one 16-bit operation, checking every cycle from start to the cycle after done
  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic [15:0] exp_sum, input logic exp_cout);
    logic [8:0] lo;
    lo = {1'b0, a[7:0]} + {1'b0, b[7:0]} + 9'(cin);
    if16.in_a = a; if16.in_b = b; if16.in_cin = cin; if16.start = 1'b1;
    @(negedge clk);
    // operands change after capture; they must have no effect
    if16.start = 1'b0; if16.in_a = ~a; if16.in_b = ~b; if16.in_cin = ~cin;
    check({tag, ".r1.add_a"},  64'(if16.add_a),  64'(a[7:0]));
    check({tag, ".r1.add_b"},  64'(if16.add_b),  64'(b[7:0]));
    check({tag, ".r1.add_c0"}, 64'(if16.add_c0), 64'(cin));
    check({tag, ".r1.busy"},   64'(if16.busy),   64'(1));
    check({tag, ".r1.done"},   64'(if16.done),   64'(0));
    @(negedge clk);
    check({tag, ".r2.add_a"},  64'(if16.add_a),  64'(a[15:8]));
    check({tag, ".r2.add_b"},  64'(if16.add_b),  64'(b[15:8]));
    check({tag, ".r2.add_c0"}, 64'(if16.add_c0), 64'(lo[8]));
    check({tag, ".r2.done"},   64'(if16.done),   64'(0));
    @(negedge clk);
    check({tag, ".done"},      64'(if16.done),   64'(1));
    check({tag, ".busy"},      64'(if16.busy),   64'(0));
    check({tag, ".sum"},       64'(if16.sum),    64'(exp_sum));
    check({tag, ".cout"},      64'(if16.cout),   64'(exp_cout));
    check({tag, ".add_a0"},    64'(if16.add_a),  64'(0));
    check({tag, ".add_c00"},   64'(if16.add_c0), 64'(0));
    @(negedge clk);
    check({tag, ".done_off"},  64'(if16.done),   64'(0));
    check({tag, ".sum_hold"},  64'(if16.sum),    64'(exp_sum));
  endtask

  logic [15:0] hs_a [12];
  logic [15:0] hs_b [12];
  logic        hs_c [12];
  logic [16:0] hs_exp;
  logic [31:0] ra, rb;
  logic        rc;
  logic [8:0]  g8;
  logic [16:0] g16;
  logic [32:0] g32;

  initial begin
    rst_n = 1'b0;
    if8.start = 1'b0;  if8.in_a = '0;  if8.in_b = '0;  if8.in_cin = 1'b0;
    if16.start = 1'b0; if16.in_a = '0; if16.in_b = '0; if16.in_cin = 1'b0;
    if32.start = 1'b0; if32.in_a = '0; if32.in_b = '0; if32.in_cin = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst.busy",   64'(if16.busy),   64'(0));
    check("rst.done",   64'(if16.done),   64'(0));
    check("rst.sum",    64'(if16.sum),    64'(0));
    check("rst.cout",   64'(if16.cout),   64'(0));
    check("rst.add_a",  64'(if16.add_a),  64'(0));
    check("rst.add_b",  64'(if16.add_b),  64'(0));
    check("rst.add_c0", 64'(if16.add_c0), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // byte carry ripple and carry extremes
    op16("ff_01",   16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    op16("ffff_01", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    op16("ffff_ff", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    op16("zero_c1", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);

    // start held high, operands changing every cycle: accepted every 4 cycles
    for (int t = 0; t < 12; t++) begin
      if (t > 0) begin
        check($sformatf("hold.t%0d.done", t), 64'(if16.done), 64'((t % 4) == 3));
        if ((t % 4) == 3) begin
          hs_exp = {1'b0, hs_a[t-3]} + {1'b0, hs_b[t-3]} + 17'(hs_c[t-3]);
          check($sformatf("hold.t%0d.sum", t),  64'(if16.sum),  64'(hs_exp[15:0]));
          check($sformatf("hold.t%0d.cout", t), 64'(if16.cout), 64'(hs_exp[16]));
        end
      end
      hs_a[t] = 16'h8F31 + 16'(t) * 16'h1357;
      hs_b[t] = 16'h70D2 + 16'(t) * 16'h0A0B;
      hs_c[t] = t[0];
      if16.in_a = hs_a[t]; if16.in_b = hs_b[t]; if16.in_cin = hs_c[t];
      if16.start = 1'b1;
      @(negedge clk);
    end
    check("hold.t12.done", 64'(if16.done), 64'(0));
    if16.start = 1'b0;
    @(negedge clk);

    // reset one cycle after the first RUN edge aborts the operation
    if16.in_a = 16'h1234; if16.in_b = 16'h5678; if16.in_cin = 1'b0; if16.start = 1'b1;
    @(negedge clk);
    if16.start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort.busy",  64'(if16.busy),  64'(0));
    check("abort.done",  64'(if16.done),  64'(0));
    check("abort.sum",   64'(if16.sum),   64'(0));
    check("abort.add_a", 64'(if16.add_a), 64'(0));
    @(negedge clk);
    check("abort.no_done", 64'(if16.done), 64'(0));
    op16("after_abort", 16'h1234, 16'h5678, 1'b0, 16'h68AC, 1'b0);

    // random operands on all three widths side by side
    for (int n = 0; n < 2000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      g8  = {1'b0, ra[7:0]}  + {1'b0, rb[7:0]}  + 9'(rc);
      g16 = {1'b0, ra[15:0]} + {1'b0, rb[15:0]} + 17'(rc);
      g32 = {1'b0, ra}       + {1'b0, rb}       + 33'(rc);
      if8.in_a  = ra[7:0];  if8.in_b  = rb[7:0];  if8.in_cin  = rc; if8.start  = 1'b1;
      if16.in_a = ra[15:0]; if16.in_b = rb[15:0]; if16.in_cin = rc; if16.start = 1'b1;
      if32.in_a = ra;       if32.in_b = rb;       if32.in_cin = rc; if32.start = 1'b1;
      @(negedge clk);
      if8.start = 1'b0; if16.start = 1'b0; if32.start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        check($sformatf("rnd%0d.w8.done.c%0d", n, c),  64'(if8.done),  64'(c == 1));
        check($sformatf("rnd%0d.w16.done.c%0d", n, c), 64'(if16.done), 64'(c == 2));
        check($sformatf("rnd%0d.w32.done.c%0d", n, c), 64'(if32.done), 64'(c == 4));
        if (c == 1) begin
          check($sformatf("rnd%0d.w8.sum", n),  64'(if8.sum),  64'(g8[7:0]));
          check($sformatf("rnd%0d.w8.cout", n), 64'(if8.cout), 64'(g8[8]));
        end
        if (c == 2) begin
          check($sformatf("rnd%0d.w16.sum", n),  64'(if16.sum),  64'(g16[15:0]));
          check($sformatf("rnd%0d.w16.cout", n), 64'(if16.cout), 64'(g16[16]));
        end
        if (c == 4) begin
          check($sformatf("rnd%0d.w32.sum", n),  64'(if32.sum),  64'(g32[31:0]));
          check($sformatf("rnd%0d.w32.cout", n), 64'(if32.cout), 64'(g32[32]));
        end
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
